// File: rtl/vsmac_sequencer.sv
// vsmac_sequencer: feeds ACCUMULATIONS operand beats to a vsmac array, waits
// RESULT_LATENCY cycles, captures the packed result and hands it downstream.
module vsmac_sequencer #(
    parameter int SIZE = 6,
    parameter int WIDTH = 8,
    parameter int ACCUMULATIONS = 3,
    parameter int RESULT_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*SIZE-1:0]   in_vec,
    input  logic [WIDTH-1:0]        in_scalar,
    output logic [WIDTH*SIZE-1:0]   mac_a,
    output logic [WIDTH-1:0]        mac_b,
    output logic                    mac_enable,
    output logic                    mac_clear,
    input  logic [WIDTH*SIZE-1:0]   mac_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [WIDTH*SIZE-1:0]   res_data,
    output logic                    busy
);
    localparam int CW = $clog2(ACCUMULATIONS + 1);
    localparam int LW = $clog2(RESULT_LATENCY + 1);
    typedef enum logic [1:0] {CLEAR, FEED, WAIT, HOLD} state_t;
    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [LW-1:0] r_lat;
    logic          w_hs;
    assign in_ready = (r_state == FEED);
    assign w_hs     = in_valid & in_ready;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= CLEAR;
            r_count    <= '0;
            r_lat      <= '0;
            mac_a      <= '0;
            mac_b      <= '0;
            mac_enable <= 1'b0;
            mac_clear  <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            busy       <= 1'b0;
        end else begin
            mac_enable <= 1'b0;
            mac_clear  <= 1'b0;
            case (r_state)
                // Entered with the strobe already raised from HOLD; straight out of reset it is raised here first.
                CLEAR: begin
                    r_count <= '0;
                    r_lat   <= '0;
                    if (mac_clear) r_state <= FEED;
                    else mac_clear <= 1'b1;
                end
                FEED: if (w_hs) begin
                    mac_a      <= in_vec;
                    mac_b      <= in_scalar;
                    mac_enable <= 1'b1;
                    busy       <= 1'b1;
                    r_count    <= r_count + CW'(1);
                    if (r_count == CW'(ACCUMULATIONS - 1)) r_state <= WAIT;
                end
                // r_lat is 0 in the final beat's enable cycle.
                WAIT: if (r_lat == LW'(RESULT_LATENCY)) begin
                    res_data  <= mac_out;
                    res_valid <= 1'b1;
                    r_state   <= HOLD;
                end else begin
                    r_lat <= r_lat + LW'(1);
                end
                HOLD: if (res_ready) begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    mac_clear <= 1'b1;
                    r_state   <= CLEAR;
                end
            endcase
        end
    end
endmodule
